// File: rtl/ras_pkg.sv
// Shared types and the per-lane step function for the multi-lane return address stack.
// The module parameters of ras_multi_lane must match RAS_XLEN / RAS_AW here.
package ras_pkg;
  localparam int RAS_XLEN = 32;
  localparam int RAS_AW   = 3;
  localparam int DEPTH    = 2 ** RAS_AW;
  localparam int CNT_W    = RAS_AW + 1;

  typedef struct packed {
    logic [RAS_AW-1:0] sp;
    logic [CNT_W-1:0]  cnt;
  } ras_ptr_t;

  typedef struct packed {
    logic [RAS_AW-1:0]   sp;
    logic [CNT_W-1:0]    cnt;
    logic [RAS_XLEN-1:0] target;
    logic                valid;
  } ras_step_t;

  // One lane: pop first (if non-empty), then push. 'top' is the entry at state.sp.
  function automatic ras_step_t ras_step(input ras_ptr_t state, input logic push,
                                         input logic pop, input logic [RAS_XLEN-1:0] top);
    ras_step_t r;
    r.sp     = state.sp;
    r.cnt    = state.cnt;
    r.target = '0;
    r.valid  = 1'b0;
    if (pop && (state.cnt != '0)) begin
      r.target = top;
      r.valid  = 1'b1;
      r.sp     = r.sp - RAS_AW'(1);
      r.cnt    = r.cnt - CNT_W'(1);
    end
    if (push) begin
      r.sp = r.sp + RAS_AW'(1);
      if (r.cnt != CNT_W'(DEPTH)) r.cnt = r.cnt + CNT_W'(1);
    end
    return r;
  endfunction
endpackage

// File: rtl/ras_multi_lane.sv
// Circular return address stack serving LANES predecode lanes per cycle, with in-cycle
// bypass between lanes, per-lane checkpoints and restore from a rollback checkpoint.
module ras_multi_lane
  import ras_pkg::*;
#(
  parameter int XLEN         = RAS_XLEN,
  parameter int RAS_ADDRESS  = RAS_AW,
  parameter int LANES        = 2,
  parameter int SNAP_ENTRIES = 2
) (
  input  logic                                CLK,
  input  logic                                reset,
  input  logic [LANES-1:0]                    pd_push,
  input  logic [LANES-1:0]                    pd_pop,
  input  logic [LANES*XLEN-1:0]               pd_push_addr,
  output logic [LANES*XLEN-1:0]               pd_pop_target,
  output logic [LANES-1:0]                    pd_pop_valid,
  output logic [LANES*RAS_ADDRESS-1:0]        pd_sp_snap,
  output logic [LANES*(RAS_ADDRESS+1)-1:0]    pd_cnt_snap,
  output logic [LANES*SNAP_ENTRIES*XLEN-1:0]  pd_ras_snap,
  input  logic                                restore_ras,
  input  logic [RAS_ADDRESS-1:0]              rb_sp_snap,
  input  logic [RAS_ADDRESS:0]                rb_cnt_snap,
  input  logic [SNAP_ENTRIES*XLEN-1:0]        rb_ras_snap
);

  logic [DEPTH-1:0][XLEN-1:0] mem_q, mem_d;
  logic [RAS_ADDRESS-1:0]     sp_q, sp_d;
  logic [RAS_ADDRESS:0]       cnt_q, cnt_d;

  // Each lane works on its own copy of the array so later lanes see earlier pushes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DEPTH-1:0][XLEN-1:0] mem_in;
    logic [DEPTH-1:0][XLEN-1:0] mem_out;
    ras_ptr_t                   st_in;
    ras_step_t                  step;

    if (i == 0) begin : g_first
      assign mem_in = mem_q;
      assign st_in  = '{sp: sp_q, cnt: cnt_q};
    end else begin : g_next
      assign mem_in = g_lane[i-1].mem_out;
      assign st_in  = '{sp: g_lane[i-1].step.sp, cnt: g_lane[i-1].step.cnt};
    end

    always_comb begin
      step    = ras_step(st_in, pd_push[i], pd_pop[i], mem_in[st_in.sp]);
      mem_out = mem_in;
      if (pd_push[i]) mem_out[step.sp] = pd_push_addr[i*XLEN +: XLEN];
    end

    assign pd_pop_target[i*XLEN +: XLEN]                 = step.target;
    assign pd_pop_valid[i]                               = step.valid;
    assign pd_sp_snap[i*RAS_ADDRESS +: RAS_ADDRESS]      = step.sp;
    assign pd_cnt_snap[i*(RAS_ADDRESS+1) +: RAS_ADDRESS+1] = step.cnt;

    for (genvar k = 0; k < SNAP_ENTRIES; k++) begin : g_snap
      assign pd_ras_snap[(i*SNAP_ENTRIES+k)*XLEN +: XLEN] =
        mem_out[step.sp - RAS_ADDRESS'(k)];
    end
  end

  // Restore wins over the lanes; the lane outputs above still reflect the pre-restore state.
  always_comb begin
    mem_d = g_lane[LANES-1].mem_out;
    sp_d  = g_lane[LANES-1].step.sp;
    cnt_d = g_lane[LANES-1].step.cnt;
    if (restore_ras) begin
      mem_d = mem_q;
      sp_d  = rb_sp_snap;
      cnt_d = rb_cnt_snap;
      for (int k = 0; k < SNAP_ENTRIES; k++) begin
        mem_d[rb_sp_snap - RAS_ADDRESS'(k)] = rb_ras_snap[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      sp_q  <= RAS_ADDRESS'(DEPTH - 1);
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
